lab1_serial_adder: RTL

- Bit-serial WIDTH-bit adder built around the team's one-bit full adder `lab1_1`.
- Accepts two operands and a carry-in on a start strobe, then feeds one bit pair per cycle, LSB first, into a single `lab1_1` instance.
- Captures the `sum`/`cout` bits it produces in a shift register and a carry flop.
- Presents a registered WIDTH-bit result and a done pulse to the downstream consumer.

---
 rtl/lab1_pkg.sv | 27 ++
 rtl/lab1_serial_adder_if.sv | 29 ++
 rtl/lab1_1.sv | 17 +
 rtl/lab1_serial_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab1_pkg
// Purpose  : Shared state encoding, default width and counter sizing helper
//            for the bit-serial adder.
// Revision : 1.0  initial release
// ============================================================================
package lab1_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter must hold indices 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        if (w <= 1) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab1_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : lab1_serial_adder_if
// Purpose  : Request/result bundle of the bit-serial adder. The ovf signal
//            exists only when LAB1_SERIAL_OVF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface lab1_serial_adder_if #(
    parameter int WIDTH = lab1_pkg::WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef LAB1_SERIAL_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/lab1_1.sv
`default_nettype none
// ============================================================================
// Module   : lab1_1
// Purpose  : One-bit full adder used as the bit slice of the serial adder.
// Revision : 1.0  initial release
// ============================================================================
module lab1_1 (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/lab1_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : lab1_serial_adder
// Purpose  : Bit-serial WIDTH-bit adder, LSB first through one lab1_1 slice.
//            Define LAB1_SERIAL_OVF_EN to add the registered ovf output.
// Revision : 1.0  initial release
// ============================================================================
module lab1_serial_adder
    import lab1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    lab1_serial_adder_if.slave bus
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_s_shift;
    logic             w_accept;
    logic             w_last;

    lab1_1 u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign w_s_shift = (s_sh_q >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));
    assign w_accept  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_last    = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = w_s_shift;
                carry_d = w_fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (w_last) begin
                    sum_d   = w_s_shift;
                    cout_d  = w_fa_cout;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef LAB1_SERIAL_OVF_EN
    logic ovf_q, ovf_d;

    // On the last bit, carry_q is the carry into the MSB slice.
    always_comb begin
        ovf_d = ovf_q;
        if (w_last) begin
            ovf_d = carry_q ^ w_fa_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
`default_nettype wire
